// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: legal ALU opcodes, an opcode legality
// helper and the response-slot state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRA = 4'b1110,
    ALU_SRL = 4'b1000
  } alu_op_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // True when the code is one of the eight opcodes the ALU implements.
  function automatic logic is_legal_op(input alu_op_t op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_SLT, ALU_SLL, ALU_SRA, ALU_SRL: is_legal_op = 1'b1;
      default:                            is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Fixed 32-bit combinational ALU. lt is the signed a<b comparison; zero
// flags an all-zero result. Illegal opcodes produce an undefined result.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alucontrol,
  output logic [31:0] result,
  output logic        zero,
  output logic        lt
);

  // Opcode decode and flag generation.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // can leave a value unassigned and infer a latch.
    result = 'x;
    lt     = ($signed(a) < $signed(b));
    case (alu_op_t'(alucontrol))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, lt};
      ALU_SLL: result = a << b[4:0];
      ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SRL: result = a >> b[4:0];
      default: result = 'x;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr, wrapping mod N, and
// grants the first active one. Pointer storage lives in the parent.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   idx;
  logic found;

  // Priority scan p, p+1, ... with at most one grant issued.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters with round-robin grant and a single
// registered response slot tagged with the requester id.
// Optional build macro ALU_ARB_OPCHECK_EN: illegal opcodes return a zeroed
// response with rsp_err=1; without it rsp_err is tied low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 32,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*4-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_lt,
  output logic                  rsp_err
);

  slot_state_t      state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_lt_q, rsp_lt_d;
  logic             rsp_err_q, rsp_err_d;

  logic             slot_free;
  logic             arb_en;
  logic             accept;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_lt;

  // A full slot can be drained and refilled in the same cycle. No grant is
  // offered while reset is held low.
  assign slot_free = (state_q == SLOT_EMPTY) || rsp_ready;
  assign arb_en    = slot_free && reset;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  // Steer the granted requester's opcode and operands into the ALU.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_sel = req_op[4*i +: 4];
        a_sel  = req_a[WIDTH*i +: WIDTH];
        b_sel  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  alu u_alu (
    .a          (a_sel),
    .b          (b_sel),
    .alucontrol (op_sel),
    .result     (alu_result),
    .zero       (alu_zero),
    .lt         (alu_lt)
  );

  // Slot FSM, response capture and round-robin pointer update.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_lt_d     = rsp_lt_q;
    rsp_err_d    = rsp_err_q;
    if (accept) begin
      state_d      = SLOT_FULL;
      ptr_d        = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      rsp_id_d     = gnt_idx;
`ifdef ALU_ARB_OPCHECK_EN
      if (is_legal_op(alu_op_t'(op_sel))) begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_lt_d     = alu_lt;
        rsp_err_d    = 1'b0;
      end else begin
        rsp_result_d = '0;
        rsp_zero_d   = 1'b0;
        rsp_lt_d     = 1'b0;
        rsp_err_d    = 1'b1;
      end
`else
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      rsp_lt_d     = alu_lt;
      rsp_err_d    = 1'b0;
`endif
    end else if (state_q == SLOT_FULL && rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q      <= SLOT_EMPTY;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_lt_q     <= rsp_lt_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = (state_q == SLOT_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_lt     = rsp_lt_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: one NREQ=2 and one NREQ=4 instance
// sharing clock and reset. Inputs change 1ns after the rising edge; outputs
// are sampled a further 1ns later.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // NREQ=2 instance signals
  logic [1:0]  v2, rdy2;
  logic [7:0]  op2;
  logic [63:0] a2, b2;
  logic        rr2, rv2, z2, lt2, err2;
  logic [0:0]  id2;
  logic [31:0] res2;

  // NREQ=4 instance signals
  logic [3:0]   v4, rdy4;
  logic [15:0]  op4;
  logic [127:0] a4, b4;
  logic         rr4, rv4, z4, lt4, err4;
  logic [1:0]   id4;
  logic [31:0]  res4;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.NREQ(2), .WIDTH(32)) u2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_op(op2),
    .req_a(a2), .req_b(b2), .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(id2),
    .rsp_result(res2), .rsp_zero(z2), .rsp_lt(lt2), .rsp_err(err2)
  );

  alu_arbiter #(.NREQ(4), .WIDTH(32)) u4 (
    .clk(clk), .reset(reset), .req_valid(v4), .req_ready(rdy4), .req_op(op4),
    .req_a(a4), .req_b(b4), .rsp_valid(rv4), .rsp_ready(rr4), .rsp_id(id4),
    .rsp_result(res4), .rsp_zero(z4), .rsp_lt(lt4), .rsp_err(err4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    v2 = '0; op2 = '0; a2 = '0; b2 = '0; rr2 = 1'b0;
    v4 = '0; op4 = '0; a4 = '0; b4 = '0; rr4 = 1'b0;

    // Reset: slot empty, outputs cleared, grants suppressed despite requests
    v2 = 2'b11;
    tick();
    tick();
    #1;
    check("rst_ready2", rdy2, 2'b00);
    check("rst_valid2", rv2, 1'b0);
    check("rst_result2", res2, 32'd0);
    check("rst_id2", id2, 1'b0);
    check("rst_err2", err2, 1'b0);
    check("rst_valid4", rv4, 1'b0);
    v2 = 2'b00;
    reset = 1'b1;
    tick();

    // Test 1: req0 alone, add 5+7
    v2 = 2'b01; op2[3:0] = 4'b0000; a2[31:0] = 32'd5; b2[31:0] = 32'd7;
    #1;
    check("t1_ready", rdy2, 2'b01);
    tick();
    v2 = 2'b00;
    #1;
    check("t1_valid", rv2, 1'b1);
    check("t1_result", res2, 32'd12);
    check("t1_id", id2, 1'b0);
    check("t1_zero", z2, 1'b0);

    // Drain and refill in one cycle: req1 and 0xF0 & 0x3C
    rr2 = 1'b1; v2 = 2'b10; op2[7:4] = 4'b0010; a2[63:32] = 32'hF0; b2[63:32] = 32'h3C;
    #1;
    check("refill_ready", rdy2, 2'b10);
    tick();
    #1;
    check("refill_valid", rv2, 1'b1);
    check("refill_id", id2, 1'b1);
    check("refill_result", res2, 32'h30);

    // Test 2: both requesting, pointer now 0 -> grants 0,1,0,1
    v2 = 2'b11;
    op2 = {4'b0001, 4'b0000};
    a2  = {32'd10, 32'd1};
    b2  = {32'd4,  32'd2};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_ready", rdy2, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("t2_valid", rv2, 1'b1);
      check("t2_id", id2, (i % 2 == 0) ? 1'b0 : 1'b1);
      check("t2_result", res2, (i % 2 == 0) ? 32'd3 : 32'd6);
    end
    v2 = 2'b00;
    tick();
    check("t2_drained", rv2, 1'b0);

    // Test 3: fill with 3-3, hold 4 cycles with consumer stalled
    rr2 = 1'b0; v2 = 2'b01;
    op2 = {4'b0011, 4'b0001};
    a2  = {32'd5, 32'd3};
    b2  = {32'd2, 32'd3};
    #1;
    check("t3_fill_ready", rdy2, 2'b01);
    tick();
    v2 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_hold_ready", rdy2, 2'b00);
      check("t3_hold_valid", rv2, 1'b1);
      check("t3_hold_result", res2, 32'd0);
      check("t3_hold_zero", z2, 1'b1);
      check("t3_hold_id", id2, 1'b0);
      tick();
    end
    rr2 = 1'b1;
    #1;
    check("t3_refill_ready", rdy2, 2'b10);
    tick();
    v2 = 2'b00;
    #1;
    check("t3_refill_id", id2, 1'b1);
    check("t3_refill_result", res2, 32'd7);
    check("t3_refill_zero", z2, 1'b0);
    tick();

    // Test 4: NREQ=4, move pointer to 2 via a lone req1 grant
    rr4 = 1'b1; v4 = 4'b0010;
    op4 = '0;
    a4[63:32] = 32'd1; b4[63:32] = 32'd1;
    a4[127:96] = 32'd30; b4[127:96] = 32'd3;
    #1;
    check("t4_setup_ready", rdy4, 4'b0010);
    tick();
    check("t4_setup_id", id4, 2'd1);
    check("t4_setup_result", res4, 32'd2);
    // req1 and req3 with p=2: expect 3,1,3,1,...
    v4 = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t4_ready", rdy4, (i % 2 == 0) ? 4'b1000 : 4'b0010);
      tick();
      check("t4_id", id4, (i % 2 == 0) ? 2'd3 : 2'd1);
      check("t4_result", res4, (i % 2 == 0) ? 32'd33 : 32'd2);
    end
    v4 = 4'b0000;
    tick();
    check("t4_drained", rv4, 1'b0);

    // Test 6: illegal opcode 0100, then slt -1 < 1
    rr2 = 1'b1; v2 = 2'b01; op2[3:0] = 4'b0100; a2[31:0] = 32'd1; b2[31:0] = 32'd1;
    tick();
    check("t6_ill_valid", rv2, 1'b1);
`ifdef ALU_ARB_OPCHECK_EN
    check("t6_ill_err", err2, 1'b1);
    check("t6_ill_result", res2, 32'd0);
    check("t6_ill_zero", z2, 1'b0);
`else
    check("t6_ill_err", err2, 1'b0);
`endif
    check("t6_ill_id", id2, 1'b0);
    op2[3:0] = 4'b0101; a2[31:0] = 32'hFFFF_FFFF; b2[31:0] = 32'd1;
    tick();
    v2 = 2'b00;
    #1;
    check("t6_slt_result", res2, 32'd1);
    check("t6_slt_lt", lt2, 1'b1);
    check("t6_slt_err", err2, 1'b0);
    tick();

    // Test 5: reset while a response is held (pointer is 1 before reset)
    rr2 = 1'b0; v2 = 2'b01; op2[3:0] = 4'b0000; a2[31:0] = 32'd5; b2[31:0] = 32'd7;
    tick();
    check("t5_full", rv2, 1'b1);
    v2 = 2'b11; reset = 1'b0;
    #1;
    check("t5_rst_ready", rdy2, 2'b00);
    tick();
    check("t5_rst_valid", rv2, 1'b0);
    check("t5_rst_result", res2, 32'd0);
    check("t5_rst_id", id2, 1'b0);
    check("t5_rst_zero", z2, 1'b0);
    check("t5_rst_lt", lt2, 1'b0);
    check("t5_rst_err", err2, 1'b0);
    check("t5_rst_ready_held", rdy2, 2'b00);
    reset = 1'b1; rr2 = 1'b1;
    #1;
    check("t5_post_ready", rdy2, 2'b01);
    tick();
    check("t5_post_id", id2, 1'b0);
    check("t5_post_valid", rv2, 1'b1);
    v2 = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
